// File: rtl/pe_link_tx.sv
// Credit-based link transmitter: buffers a local word stream in a FIFO and
// injects at most one word per cycle onto the east link while credit remains.
module pe_link_tx #(
   parameter int DATA_WIDTH      = 32,
   parameter int EAST_WIDTH      = 130,
   parameter int FIFO_DEPTH_BITS = 3,
   parameter int CREDITS         = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ap_start,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic                       din_last,
   input  logic                       din_valid,
   output logic                       din_ready,
   input  logic [EAST_WIDTH-1:0]      in_from_east,
   output logic [EAST_WIDTH-1:0]      out_to_east,
   output logic [7:0]                 credit_count,
   output logic [FIFO_DEPTH_BITS:0]   fifo_count,
   output logic                       credit_err
);

   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam logic [FIFO_DEPTH_BITS:0] DEPTH_CNT = (FIFO_DEPTH_BITS+1)'(DEPTH);
   localparam logic [7:0] CREDIT_MAX = 8'(CREDITS);

   // Handshake: a word transfers on any rising edge where din_valid and
   // din_ready are both high; din_ready depends only on the registered count.
   logic [DATA_WIDTH:0]        mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
   logic [DATA_WIDTH:0]        head;
   logic                       push;
   logic                       pop;
   logic                       credit_in;
   logic                       unused_bits;

   assign din_ready   = (fifo_count != DEPTH_CNT);
   assign push        = din_valid && din_ready;
   assign pop         = ap_start && (fifo_count != '0) && (credit_count != 8'd0);
   assign credit_in   = in_from_east[0];
   assign head        = mem[rd_ptr];
   assign unused_bits = ^in_from_east[EAST_WIDTH-1:1];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {din_last, din};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         credit_count <= CREDIT_MAX;
         credit_err   <= 1'b0;
         out_to_east  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (FIFO_DEPTH_BITS)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (FIFO_DEPTH_BITS)'(1);
         end

         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (FIFO_DEPTH_BITS+1)'(1);
            2'b01:   fifo_count <= fifo_count - (FIFO_DEPTH_BITS+1)'(1);
            default: fifo_count <= fifo_count;
         endcase

         // A returning credit at the ceiling is a protocol error by the receiver.
         if (pop && !credit_in) begin
            credit_count <= credit_count - 8'd1;
         end else if (!pop && credit_in) begin
            if (credit_count == CREDIT_MAX) begin
               credit_err <= 1'b1;
            end else begin
               credit_count <= credit_count + 8'd1;
            end
         end

         // The link carries a one-cycle beat per word; idle cycles drive zero.
         out_to_east <= '0;
         if (pop) begin
            out_to_east[DATA_WIDTH-1:0] <= head[DATA_WIDTH-1:0];
            out_to_east[DATA_WIDTH]     <= 1'b1;
            out_to_east[DATA_WIDTH+1]   <= head[DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_pe_link_tx.sv
// Directed bench for pe_link_tx: beat data is scoreboarded against an expected
// queue, timing/credit/occupancy values are hand-computed per cycle.
module tb_pe_link_tx;

   localparam int DW = 32;
   localparam int EW = 130;
   localparam int FB = 3;

   logic          clk;
   logic          reset;
   logic          ap_start;
   logic [DW-1:0] din;
   logic          din_last;
   logic          din_valid;
   logic          din_ready;
   logic [EW-1:0] in_from_east;
   logic [EW-1:0] out_to_east;
   logic [7:0]    credit_count;
   logic [FB:0]   fifo_count;
   logic          credit_err;

   int checks = 0;
   int errors = 0;
   logic [DW+1:0] exp_q[$];

   pe_link_tx #(
      .DATA_WIDTH(DW), .EAST_WIDTH(EW), .FIFO_DEPTH_BITS(FB), .CREDITS(4)
   ) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start),
      .din(din), .din_last(din_last), .din_valid(din_valid), .din_ready(din_ready),
      .in_from_east(in_from_east), .out_to_east(out_to_east),
      .credit_count(credit_count), .fifo_count(fifo_count), .credit_err(credit_err)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW+1:0] beat(input logic [DW-1:0] d, input logic l);
      return {l, 1'b1, d};
   endfunction

   task automatic push_word(input logic [DW-1:0] d, input logic l);
      din       = d;
      din_last  = l;
      din_valid = 1'b1;
   endtask

   // scoreboard: every valid beat must match the next expected word
   always @(posedge clk) begin
      #1;
      if (out_to_east[DW] === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("beat_unexpected", 160'(out_to_east[DW+1:0]), 160'd0);
         end else begin
            check("beat_data", 160'(out_to_east[DW+1:0]), 160'(exp_q.pop_front()));
         end
         check("beat_upper_zero", 160'(out_to_east[EW-1:DW+2]), 160'd0);
      end
   end

   initial begin
      reset = 1'b1; ap_start = 1'b1; din = 32'hAAAA5555; din_last = 1'b0;
      din_valid = 1'b1; in_from_east = '0;

      // reset state with traffic present on the inputs
      step(); step();
      check("rst_out", 160'(out_to_east), 160'd0);
      check("rst_credit", 160'(credit_count), 160'd4);
      check("rst_fifo", 160'(fifo_count), 160'd0);
      check("rst_ready", 160'(din_ready), 160'd1);
      check("rst_err", 160'(credit_err), 160'd0);
      reset = 1'b0; din_valid = 1'b0;
      step();
      check("post_rst_out", 160'(out_to_east), 160'd0);
      check("post_rst_fifo", 160'(fifo_count), 160'd0);
      check("post_rst_credit", 160'(credit_count), 160'd4);

      // single word: latency of one edge after acceptance
      push_word(32'h12345678, 1'b1);
      exp_q.push_back(beat(32'h12345678, 1'b1));
      step();
      din_valid = 1'b0;
      check("single_fifo", 160'(fifo_count), 160'd1);
      check("single_no_fallthru", 160'(out_to_east), 160'd0);
      step();
      check("single_out", 160'(out_to_east), 160'h3_1234_5678);
      check("single_credit", 160'(credit_count), 160'd3);
      step();
      check("single_idle", 160'(out_to_east), 160'd0);
      in_from_east = 130'd1;
      step();
      in_from_east = '0;
      check("single_credit_back", 160'(credit_count), 160'd4);

      // six words, four credits: four back-to-back beats then a stall
      for (int i = 0; i < 6; i++) begin
         push_word(32'h100 + 32'(i), i == 5);
         exp_q.push_back(beat(32'h100 + 32'(i), i == 5));
         step();
         check("burst_valid", 160'(out_to_east[DW]), 160'((i >= 1 && i <= 4) ? 1 : 0));
      end
      din_valid = 1'b0;
      check("burst_credit", 160'(credit_count), 160'd0);
      check("burst_fifo", 160'(fifo_count), 160'd2);
      step();
      check("burst_stall", 160'(out_to_east[DW]), 160'd0);
      for (int k = 0; k < 2; k++) begin
         in_from_east = 130'd1;
         step();
         in_from_east = '0;
         check("burst_cr_in", 160'(credit_count), 160'd1);
         check("burst_cr_nobeat", 160'(out_to_east[DW]), 160'd0);
         step();
         check("burst_cr_beat", 160'(out_to_east[DW]), 160'd1);
         check("burst_cr_used", 160'(credit_count), 160'd0);
      end
      check("burst_drained", 160'(fifo_count), 160'd0);

      // restore full credit
      in_from_east = 130'd1;
      repeat (4) step();
      in_from_east = '0;
      check("refill_credit", 160'(credit_count), 160'd4);
      check("refill_err", 160'(credit_err), 160'd0);

      // steady stream with a credit back every cycle, wraps the FIFO pointers
      for (int i = 0; i < 20; i++) begin
         push_word(32'hC0DE0000 + 32'(i), i[1:0] == 2'd3);
         exp_q.push_back(beat(32'hC0DE0000 + 32'(i), i[1:0] == 2'd3));
         step();
         if (i >= 1) begin
            check("stream_valid", 160'(out_to_east[DW]), 160'd1);
            check("stream_credit", 160'(credit_count), 160'd3);
            check("stream_fifo", 160'(fifo_count), 160'd1);
            in_from_east = 130'd1;
         end
      end
      din_valid = 1'b0;
      step();
      in_from_east = '0;
      check("stream_last_valid", 160'(out_to_east[DW]), 160'd1);
      check("stream_end_credit", 160'(credit_count), 160'd3);
      check("stream_end_fifo", 160'(fifo_count), 160'd0);
      in_from_east = 130'd1;
      step();
      in_from_east = '0;
      check("stream_credit_back", 160'(credit_count), 160'd4);

      // ap_start low: FIFO fills to 8, ninth word waits
      ap_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         push_word(32'h9000 + 32'(i), 1'b0);
         exp_q.push_back(beat(32'h9000 + 32'(i), 1'b0));
         check("fill_ready", 160'(din_ready), 160'((i < 8) ? 1 : 0));
         step();
         check("fill_no_send", 160'(out_to_east[DW]), 160'd0);
      end
      check("fill_fifo", 160'(fifo_count), 160'd8);
      check("fill_ready_full", 160'(din_ready), 160'd0);
      ap_start = 1'b1;
      step();
      check("resume_beat0", 160'(out_to_east[DW]), 160'd1);
      check("resume_fifo0", 160'(fifo_count), 160'd7);
      check("resume_ready", 160'(din_ready), 160'd1);
      step();
      din_valid = 1'b0;
      check("resume_beat1", 160'(out_to_east[DW]), 160'd1);
      check("resume_fifo1", 160'(fifo_count), 160'd7);
      step();
      step();
      check("resume_beat3", 160'(out_to_east[DW]), 160'd1);
      check("resume_credit", 160'(credit_count), 160'd0);
      check("resume_fifo3", 160'(fifo_count), 160'd5);
      step();
      check("resume_stall", 160'(out_to_east[DW]), 160'd0);

      // drain the remaining five words and return to full credit
      in_from_east = 130'd1;
      repeat (9) step();
      in_from_east = '0;
      step();
      check("drain_credit", 160'(credit_count), 160'd4);
      check("drain_fifo", 160'(fifo_count), 160'd0);
      check("drain_err", 160'(credit_err), 160'd0);
      check("drain_sb_empty", 160'(exp_q.size()), 160'd0);

      // credit overflow is sticky
      in_from_east = 130'd1;
      step();
      in_from_east = '0;
      check("ovf_err", 160'(credit_err), 160'd1);
      check("ovf_credit", 160'(credit_count), 160'd4);
      step();
      check("ovf_sticky", 160'(credit_err), 160'd1);

      // reset mid-stream discards buffered words
      ap_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_word(32'hDEAD0000 + 32'(i), 1'b0);
         step();
      end
      din_valid = 1'b0;
      check("mid_fifo", 160'(fifo_count), 160'd3);
      ap_start = 1'b1;
      reset = 1'b1;
      step();
      check("mid_rst_out", 160'(out_to_east), 160'd0);
      check("mid_rst_fifo", 160'(fifo_count), 160'd0);
      check("mid_rst_credit", 160'(credit_count), 160'd4);
      check("mid_rst_err", 160'(credit_err), 160'd0);
      check("mid_rst_ready", 160'(din_ready), 160'd1);
      reset = 1'b0;
      step();
      step();
      check("mid_post_out", 160'(out_to_east), 160'd0);
      check("mid_post_fifo", 160'(fifo_count), 160'd0);
      check("final_sb_empty", 160'(exp_q.size()), 160'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
